apb_master_nslv: RTL and testbench

- Parametrised APB master bridge; successor to the fixed two-slave, 33-bit-address APB block.
- Accepts single read/write requests on a valid/ready request port and runs APB SETUP/ACCESS phases toward NSLV slaves.
- Decodes the slave from the top address bits and supports PREADY wait states and PSLVERR.
- Returns read data and error status on a one-cycle response strobe.

---
 rtl/apb_master_nslv.sv | 144 ++++++++++++++
 tb/tb_apb_master_nslv.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master_nslv.sv
// APB master bridge: one valid/ready request at a time, decoded to NSLV slaves by the top address bits.
// Optional ACCESS-phase watchdog is compiled in with `define APB_TIMEOUT_EN.
module apb_master_nslv #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int NSLV    = 4,
    parameter int SEL_W   = $clog2(NSLV),
    parameter int TIMEOUT = 16
) (
    input  logic                   PCLK,
    input  logic                   PRESET,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_write,
    input  logic [ADDR_W-1:0]      req_addr,
    input  logic [DATA_W-1:0]      req_wdata,
    output logic                   rsp_valid,
    output logic [DATA_W-1:0]      rsp_rdata,
    output logic                   rsp_err,
    output logic [ADDR_W-1:0]      PADDR,
    output logic [NSLV-1:0]        PSEL,
    output logic                   PENABLE,
    output logic                   PWRITE,
    output logic [DATA_W-1:0]      PWDATA,
    input  logic [NSLV*DATA_W-1:0] PRDATA,
    input  logic [NSLV-1:0]        PREADY,
    input  logic [NSLV-1:0]        PSLVERR
);
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    localparam int NDEC = 2 ** SEL_W;

    state_t             state_reg;
    logic [SEL_W-1:0]   idx_reg;
    logic               err_pend_reg;
    logic [SEL_W-1:0]   req_idx;
    logic [NDEC-1:0]    slave_ok;
    logic [DATA_W-1:0]  rdata_slice [NSLV];
    logic [DATA_W-1:0]  sel_rdata;
    logic               sel_ready;
    logic               sel_err;
    logic               req_bad;
    logic               done;
    logic               accept_ok;
    logic               accept_bad;

`ifdef APB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0]   wait_cnt_reg;
`endif

    // Decode table covers every value the select field can take, so indices >= NSLV map to errors.
    genvar gi;
    generate
        for (gi = 0; gi < NDEC; gi++) begin : g_dec
            assign slave_ok[gi] = (gi < NSLV);
        end
        for (gi = 0; gi < NSLV; gi++) begin : g_rd
            assign rdata_slice[gi] = PRDATA[gi*DATA_W +: DATA_W];
        end
    endgenerate

    assign req_idx    = req_addr[ADDR_W-1 -: SEL_W];
    assign req_bad    = !slave_ok[req_idx];
    assign sel_ready  = PREADY[idx_reg];
    assign sel_err    = PSLVERR[idx_reg];
    assign sel_rdata  = rdata_slice[idx_reg];
    assign done       = (state_reg == ACCESS) && sel_ready;
    assign req_ready  = !PRESET && ((state_reg == IDLE) || done);
    assign accept_ok  = req_valid && req_ready && !req_bad;
    assign accept_bad = req_valid && req_ready && req_bad;

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_reg    <= IDLE;
            idx_reg      <= '0;
            err_pend_reg <= 1'b0;
            PADDR        <= '0;
            PSEL         <= '0;
            PENABLE      <= 1'b0;
            PWRITE       <= 1'b0;
            PWDATA       <= '0;
            rsp_valid    <= 1'b0;
            rsp_rdata    <= '0;
            rsp_err      <= 1'b0;
`ifdef APB_TIMEOUT_EN
            wait_cnt_reg <= '0;
`endif
        end else begin
            rsp_valid <= 1'b0;
            // A decode error taken while a transfer completes must wait one cycle for the response slot.
            err_pend_reg <= accept_bad && ((state_reg == ACCESS) || err_pend_reg);
            case (state_reg)
                IDLE: begin
                    if (err_pend_reg || accept_bad) begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_rdata <= '0;
                    end
                end
                SETUP: begin
                    PENABLE   <= 1'b1;
                    state_reg <= ACCESS;
`ifdef APB_TIMEOUT_EN
                    wait_cnt_reg <= '0;
`endif
                end
                ACCESS: begin
                    if (sel_ready) begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= sel_err;
                        rsp_rdata <= (!PWRITE && !sel_err) ? sel_rdata : '0;
                        PSEL      <= '0;
                        PENABLE   <= 1'b0;
                        state_reg <= IDLE;
                    end
`ifdef APB_TIMEOUT_EN
                    else if (wait_cnt_reg == CNT_W'(TIMEOUT - 1)) begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_rdata <= '0;
                        PSEL      <= '0;
                        PENABLE   <= 1'b0;
                        state_reg <= IDLE;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + 1'b1;
                    end
`endif
                end
                default: state_reg <= IDLE;
            endcase
            // Accepted request overrides the completion path so back-to-back skips IDLE.
            if (accept_ok) begin
                state_reg <= SETUP;
                idx_reg   <= req_idx;
                PADDR     <= req_addr;
                PWRITE    <= req_write;
                PWDATA    <= req_wdata;
                PSEL      <= NSLV'(1) << req_idx;
                PENABLE   <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_apb_master_nslv.sv
// Self-checking bench for apb_master_nslv: directed test-plan cases plus randomized transfers
// checked against expectations derived from the transfer rules (NSLV=4 main DUT, NSLV=3 decode DUT).
module tb_apb_master_nslv;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int NS = 4;
    localparam int TO = 16;

    logic           PCLK = 1'b0;
    logic           PRESET;
    logic           req_valid, req_ready, req_write;
    logic [AW-1:0]  req_addr;
    logic [DW-1:0]  req_wdata;
    logic           rsp_valid, rsp_err;
    logic [DW-1:0]  rsp_rdata;
    logic [AW-1:0]  PADDR;
    logic [NS-1:0]  PSEL;
    logic           PENABLE, PWRITE;
    logic [DW-1:0]  PWDATA;
    logic [NS*DW-1:0] PRDATA;
    logic [NS-1:0]  PREADY, PSLVERR;

    logic           d3_req_valid, d3_req_ready, d3_req_write;
    logic [AW-1:0]  d3_req_addr;
    logic [DW-1:0]  d3_req_wdata;
    logic           d3_rsp_valid, d3_rsp_err;
    logic [DW-1:0]  d3_rsp_rdata;
    logic [AW-1:0]  d3_paddr;
    logic [2:0]     d3_psel;
    logic           d3_penable, d3_pwrite;
    logic [DW-1:0]  d3_pwdata;
    logic [3*DW-1:0] d3_prdata;
    logic [2:0]     d3_pready, d3_pslverr;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 PCLK = ~PCLK;

    assign d3_prdata  = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
    assign d3_pready  = 3'b111;
    assign d3_pslverr = 3'b000;

    apb_master_nslv #(.ADDR_W(AW), .DATA_W(DW), .NSLV(NS), .TIMEOUT(TO)) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    apb_master_nslv #(.ADDR_W(AW), .DATA_W(DW), .NSLV(3), .TIMEOUT(TO)) dut3 (
        .PCLK(PCLK), .PRESET(PRESET),
        .req_valid(d3_req_valid), .req_ready(d3_req_ready), .req_write(d3_req_write),
        .req_addr(d3_req_addr), .req_wdata(d3_req_wdata),
        .rsp_valid(d3_rsp_valid), .rsp_rdata(d3_rsp_rdata), .rsp_err(d3_rsp_err),
        .PADDR(d3_paddr), .PSEL(d3_psel), .PENABLE(d3_penable), .PWRITE(d3_pwrite), .PWDATA(d3_pwdata),
        .PRDATA(d3_prdata), .PREADY(d3_pready), .PSLVERR(d3_pslverr)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One complete transfer to the NSLV=4 DUT. Called and returns at a negedge with the DUT idle.
    task automatic run_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                            input int waits, input logic err, input logic [31:0] rd);
        int          idx;
        logic [3:0]  onehot;
        logic [31:0] exp_rd;
        idx    = int'(addr[31:30]);
        onehot = 4'b0001 << idx;
        exp_rd = (!wr && !err) ? rd : 32'h0;
        req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wdata;
        PRDATA  = {$urandom, $urandom, $urandom, $urandom};
        PRDATA[idx*DW +: DW] = rd;
        PSLVERR = 4'($urandom);
        PSLVERR[idx] = err;
        PREADY  = 4'($urandom);
        PREADY[idx] = 1'b0;
        #1 chk("idle_ready", req_ready, 1'b1);
        @(negedge PCLK);
        req_valid = 1'b0;
        chk("setup_psel", PSEL, onehot);
        chk("setup_penable", PENABLE, 1'b0);
        chk("setup_paddr", PADDR, addr);
        chk("setup_pwrite", PWRITE, wr);
        chk("setup_pwdata", PWDATA, wdata);
        chk("setup_ready", req_ready, 1'b0);
        for (int w = 0; w <= waits; w++) begin
            @(negedge PCLK);
            chk("access_psel", PSEL, onehot);
            chk("access_penable", PENABLE, 1'b1);
            chk("access_paddr", PADDR, addr);
            chk("access_pwdata", PWDATA, wdata);
            chk("access_pwrite", PWRITE, wr);
            chk("access_no_rsp", rsp_valid, 1'b0);
            PREADY = 4'($urandom);
            PREADY[idx] = (w == waits);
            #1 chk("access_ready", req_ready, (w == waits));
        end
        @(negedge PCLK);
        PREADY[idx] = 1'b0;
        chk("rsp_valid", rsp_valid, 1'b1);
        chk("rsp_err", rsp_err, err);
        chk("rsp_rdata", rsp_rdata, exp_rd);
        chk("done_psel", PSEL, 4'b0000);
        chk("done_penable", PENABLE, 1'b0);
        @(negedge PCLK);
        chk("rsp_single", rsp_valid, 1'b0);
        chk("rsp_rdata_hold", rsp_rdata, exp_rd);
        chk("rsp_err_hold", rsp_err, err);
        $display("xfer wr=%0d addr=0x%08h waits=%0d err=%0d rdata=0x%08h", wr, addr, waits, err, rsp_rdata);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_cyc;
        int rsp_cnt;
        logic seen;
        PRESET = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        PRDATA = '0; PREADY = '0; PSLVERR = '0;
        d3_req_valid = 1'b0; d3_req_write = 1'b0; d3_req_addr = '0; d3_req_wdata = '0;

        // Reset state
        repeat (3) @(negedge PCLK);
        chk("rst_ready", req_ready, 1'b0);
        chk("rst_psel", PSEL, 4'b0000);
        chk("rst_penable", PENABLE, 1'b0);
        chk("rst_paddr", PADDR, 32'h0);
        chk("rst_pwdata", PWDATA, 32'h0);
        chk("rst_rsp", {rsp_valid, rsp_err, rsp_rdata}, 34'h0);
        PRESET = 1'b0;
        @(negedge PCLK);
        chk("post_rst_ready", req_ready, 1'b1);
        $display("reset checked");

        // Zero-wait write to slave 1, then 3-wait read from slave 2
        run_xfer(1'b1, 32'h4000_0010, 32'h0000_000A, 0, 1'b0, 32'h0);
        run_xfer(1'b0, 32'h8000_0020, 32'h0, 3, 1'b0, 32'h1234_5678);

        // Back-to-back: write slave 0 then read slave 3 (one wait) with req_valid held
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h0000_0004; req_wdata = 32'h55;
        PREADY = 4'b0000; PSLVERR = 4'b0000;
        PRDATA = '0; PRDATA[3*DW +: DW] = 32'hCAFE_F00D;
        #1 chk("b2b_ready0", req_ready, 1'b1);
        @(negedge PCLK);
        chk("b2b_setup1_psel", PSEL, 4'b0001);
        chk("b2b_setup1_pen", PENABLE, 1'b0);
        req_write = 1'b0; req_addr = 32'hC000_0008; req_wdata = 32'h0;
        #1 chk("b2b_setup_ready", req_ready, 1'b0);
        @(negedge PCLK);
        chk("b2b_access1_pen", PENABLE, 1'b1);
        chk("b2b_access1_pwrite", PWRITE, 1'b1);
        PREADY = 4'b0001;
        #1 chk("b2b_ready1", req_ready, 1'b1);
        @(negedge PCLK);
        req_valid = 1'b0; PREADY = 4'b0000;
        chk("b2b_rsp1", rsp_valid, 1'b1);
        chk("b2b_rsp1_rdata", rsp_rdata, 32'h0);
        chk("b2b_setup2_psel", PSEL, 4'b1000);
        chk("b2b_setup2_pen", PENABLE, 1'b0);
        chk("b2b_setup2_paddr", PADDR, 32'hC000_0008);
        @(negedge PCLK);
        chk("b2b_gap", rsp_valid, 1'b0);
        chk("b2b_wait_pen", PENABLE, 1'b1);
        @(negedge PCLK);
        chk("b2b_gap2", rsp_valid, 1'b0);
        PREADY = 4'b1000;
        @(negedge PCLK);
        PREADY = 4'b0000;
        chk("b2b_rsp2", rsp_valid, 1'b1);
        chk("b2b_rsp2_rdata", rsp_rdata, 32'hCAFE_F00D);
        chk("b2b_rsp2_err", rsp_err, 1'b0);
        @(negedge PCLK);
        chk("b2b_rsp_end", rsp_valid, 1'b0);
        $display("back-to-back checked");

        // NSLV=3 decode error on index 3, then a good read from slave 2
        d3_req_valid = 1'b1; d3_req_addr = 32'hC000_0000;
        #1 chk("dec_ready", d3_req_ready, 1'b1);
        @(negedge PCLK);
        d3_req_valid = 1'b0;
        chk("dec_rsp", d3_rsp_valid, 1'b1);
        chk("dec_err", d3_rsp_err, 1'b1);
        chk("dec_rdata", d3_rsp_rdata, 32'h0);
        chk("dec_psel", d3_psel, 3'b000);
        @(negedge PCLK);
        chk("dec_rsp_end", d3_rsp_valid, 1'b0);
        chk("dec_psel2", d3_psel, 3'b000);
        d3_req_valid = 1'b1; d3_req_addr = 32'h8000_0000;
        @(negedge PCLK);
        d3_req_valid = 1'b0;
        chk("d3_setup_psel", d3_psel, 3'b100);
        @(negedge PCLK);
        chk("d3_access_pen", d3_penable, 1'b1);
        @(negedge PCLK);
        chk("d3_rsp", d3_rsp_valid, 1'b1);
        chk("d3_rsp_err", d3_rsp_err, 1'b0);
        chk("d3_rsp_rdata", d3_rsp_rdata, 32'h3333_3333);
        $display("decode error checked");

        // PSLVERR on a read, then reset during ACCESS
        run_xfer(1'b0, 32'h0000_0100, 32'h0, 1, 1'b1, 32'hDEAD_BEEF);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h4000_0044; req_wdata = 32'h77;
        PREADY = 4'b0000;
        @(negedge PCLK);
        req_valid = 1'b0;
        @(negedge PCLK);
        chk("pre_rst_pen", PENABLE, 1'b1);
        PRESET = 1'b1;
        @(negedge PCLK);
        chk("midrst_psel", PSEL, 4'b0000);
        chk("midrst_pen", PENABLE, 1'b0);
        chk("midrst_apb", {PADDR, PWDATA, PWRITE}, 65'h0);
        chk("midrst_rsp", {rsp_valid, rsp_err, rsp_rdata}, 34'h0);
        chk("midrst_ready", req_ready, 1'b0);
        PRESET = 1'b0;
        @(negedge PCLK);
        chk("postrst_rsp", rsp_valid, 1'b0);
        chk("postrst_ready", req_ready, 1'b1);
        $display("pslverr and mid-transfer reset checked");

        // Randomized transfers against the rule-derived expectations
        for (int t = 0; t < 20; t++) begin
            logic [1:0]  ridx;
            logic [31:0] raddr;
            ridx  = 2'($urandom_range(0, 3));
            raddr = {ridx, 30'($urandom)};
            run_xfer(1'($urandom_range(0, 1)), raddr, $urandom, $urandom_range(0, 3),
                     ($urandom_range(0, 3) == 0), $urandom);
        end

        // ACCESS with PREADY held low
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h4000_0000;
        PREADY = 4'b0000;
        @(negedge PCLK);
        req_valid = 1'b0;
`ifdef APB_TIMEOUT_EN
        n_cyc = 0; seen = 1'b0;
        for (int c = 0; c < 40 && !seen; c++) begin
            @(negedge PCLK);
            if (rsp_valid) seen = 1'b1;
            else n_cyc++;
        end
        chk("to_seen", seen, 1'b1);
        chk("to_access_cycles", n_cyc, TO);
        chk("to_err", rsp_err, 1'b1);
        chk("to_rdata", rsp_rdata, 32'h0);
        chk("to_psel", PSEL, 4'b0000);
        chk("to_pen", PENABLE, 1'b0);
        PREADY = 4'b0010;
        @(negedge PCLK);
        PREADY = 4'b0000;
        chk("to_late_ready", rsp_valid, 1'b0);
        @(negedge PCLK);
        chk("to_late_ready2", rsp_valid, 1'b0);
        $display("timeout abort after %0d wait cycles", n_cyc);
`else
        rsp_cnt = 0;
        repeat (100) begin
            @(negedge PCLK);
            if (rsp_valid) rsp_cnt++;
        end
        chk("hang_no_rsp", rsp_cnt, 0);
        chk("hang_psel", PSEL, 4'b0010);
        chk("hang_pen", PENABLE, 1'b1);
        PRESET = 1'b1;
        @(negedge PCLK);
        PRESET = 1'b0;
        @(negedge PCLK);
        chk("hang_recover", req_ready, 1'b1);
        $display("no timeout: still in ACCESS after 100 cycles");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
